cpu6_bus_controller: RTL and testbench

External bus-cycle sequencer between the CPU6 microcoded datapath and system memory/IO. Accepts one read or write request at a time from microcode control, runs a setup/strobe/hold cycle on the external bus with a configurable minimum wait and `mem_ready` extension, and registers read data into a memory data register. That register is the source the datapath selects onto the internal data bus for the memory-read enable code. Also provides a busy indication for freezing the sequencer and a bus-timeout error flag.

---
 rtl/cpu6_bus_pkg.sv | 18 +
 rtl/cpu6_bus_timer.sv | 51 +++++
 rtl/cpu6_bus_controller.sv | 138 +++++++++++++
 tb/tb_cpu6_bus_controller.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_bus_pkg.sv
// Shared types and constants for the CPU6 external bus sequencer.
// Holds the bus-cycle state encoding, the abort read value and default widths.
package cpu6_bus_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  // Value loaded into the memory data register when a read times out.
  localparam logic [7:0] BUS_ABORT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } bus_state_t;

endpackage

// File: rtl/cpu6_bus_timer.sv
// Strobe timing for the CPU6 bus: a wait-state down-counter and a strobe-length
// up-counter. Both are armed by start (SETUP) and advance while run (STROBE).
module cpu6_bus_timer #(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic wait_done,
  output logic timed_out
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (start) begin
      wait_cnt_d = WAIT_LOAD;
      tmo_cnt_d  = '0;
    end else if (run) begin
      if (wait_cnt_q != 4'd0) begin
        wait_cnt_d = wait_cnt_q - 4'd1;
      end
      // tmo_cnt counts strobe cycles already completed before the current one
      if (tmo_cnt_q != TMO_LAST) begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign wait_done = (wait_cnt_q == 4'd0);
  assign timed_out = run && (tmo_cnt_q == TMO_LAST);

endmodule

// File: rtl/cpu6_bus_controller.sv
// CPU6 external bus-cycle sequencer: runs SETUP/STROBE/HOLD for one request at
// a time, registers read data into the memory data register, flags timeouts.
module cpu6_bus_controller
  import cpu6_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  input  logic              err_clear,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  bus_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              err_set;
  logic              wait_done;
  logic              timed_out;

  cpu6_bus_timer #(
    .WAIT_STATES (WAIT_STATES),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .start     (state_q == ST_SETUP),
    .run       (state_q == ST_STROBE),
    .wait_done (wait_done),
    .timed_out (timed_out)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    err_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d    = ST_SETUP;
          write_d    = req_write;
          mem_addr_d = req_addr;
          if (req_write) begin
            mem_wdata_d = req_wdata;
          end
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        // A completion in the last allowed strobe cycle beats the timeout.
        if (wait_done && mem_ready) begin
          state_d = ST_HOLD;
          if (!write_q) begin
            rd_data_d = mem_rdata;
          end
        end else if (timed_out) begin
          state_d = ST_HOLD;
          err_set = 1'b1;
          if (!write_q) begin
            rd_data_d = DATA_W'(BUS_ABORT_DATA);
          end
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    // Strobes are registered so they are glitch-free on the external bus.
    mem_rd_d = (state_d == ST_STROBE) && !write_d;
    mem_wr_d = (state_d == ST_STROBE) && write_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = ~req_ready;
  assign rd_valid  = (state_q == ST_HOLD) && !write_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_cpu6_bus_controller.sv
// Self-checking bench for cpu6_bus_controller: two instances (0 and 2 wait
// states, timeout 16) share stimulus; read data is tracked with scoreboards.
module tb_cpu6_bus_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, err_clear, mem_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, mem_rdata;

  logic        a_req_ready, a_busy, a_rd_valid, a_err, a_mem_rd, a_mem_wr;
  logic [7:0]  a_rd_data, a_mem_wdata;
  logic [15:0] a_mem_addr;
  logic        b_req_ready, b_busy, b_rd_valid, b_err, b_mem_rd, b_mem_wr;
  logic [7:0]  b_rd_data, b_mem_wdata;
  logic [15:0] b_mem_addr;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  cpu6_bus_controller #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(0), .TIMEOUT(16)) u_dut_a (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_req_ready), .busy(a_busy),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .err(a_err), .err_clear(err_clear),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  cpu6_bus_controller #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(2), .TIMEOUT(16)) u_dut_b (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_req_ready), .busy(b_busy),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .err(b_err), .err_clear(err_clear),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 1'b0; err_clear = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // One read on both instances with mem_ready high; checks data and strobe length.
  task automatic run_read(input logic [15:0] addr, input logic [7:0] data);
    int a_str = 0;
    int b_str = 0;
    logic [7:0] e;
    mem_ready = 1'b1; mem_rdata = data; req_write = 1'b0; req_addr = addr; req_valid = 1'b1;
    exp_a.push_back(data);
    exp_b.push_back(data);
    tick;
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (a_mem_rd) a_str++;
      if (b_mem_rd) b_str++;
      if (a_rd_valid) begin
        tests_run++;
        if (exp_a.size() == 0) begin
          tests_failed++; $display("FAIL sb_a_unexpected: rd_valid with data %h, expected no read", a_rd_data);
        end else begin
          e = exp_a.pop_front();
          if (a_rd_data !== e) begin
            tests_failed++; $display("FAIL read_data_a: got %h expected %h", a_rd_data, e);
          end
          $display("[TB] dut_a read addr=%h data=%h", addr, a_rd_data);
        end
      end
      if (b_rd_valid) begin
        tests_run++;
        if (exp_b.size() == 0) begin
          tests_failed++; $display("FAIL sb_b_unexpected: rd_valid with data %h, expected no read", b_rd_data);
        end else begin
          e = exp_b.pop_front();
          if (b_rd_data !== e) begin
            tests_failed++; $display("FAIL read_data_b: got %h expected %h", b_rd_data, e);
          end
          $display("[TB] dut_b read addr=%h data=%h", addr, b_rd_data);
        end
      end
      tick;
    end
    tests_run++;
    if (a_str != 1 || b_str != 3) begin
      tests_failed++; $display("FAIL strobe_len: got a=%0d b=%0d expected a=1 b=3", a_str, b_str);
    end
    tests_run++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      tests_failed++; $display("FAIL sb_leftover: got %0d/%0d pending expected 0/0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hAAAA;
    req_wdata = 8'h00; mem_rdata = 8'h00; mem_ready = 1'b1; err_clear = 1'b0;
    tick; tick;
    tests_run++;
    if ({a_req_ready, a_busy, a_mem_rd, a_mem_wr, a_rd_valid, a_err} !== 6'b100000) begin
      tests_failed++; $display("FAIL reset_flags_a: got %b expected 100000",
        {a_req_ready, a_busy, a_mem_rd, a_mem_wr, a_rd_valid, a_err});
    end
    tests_run++;
    if ({b_req_ready, b_busy, b_mem_rd, b_mem_wr, b_rd_valid, b_err} !== 6'b100000) begin
      tests_failed++; $display("FAIL reset_flags_b: got %b expected 100000",
        {b_req_ready, b_busy, b_mem_rd, b_mem_wr, b_rd_valid, b_err});
    end
    tests_run++;
    if ({a_mem_addr, a_mem_wdata, a_rd_data} !== 32'h0) begin
      tests_failed++; $display("FAIL reset_regs_a: got %h expected 0", {a_mem_addr, a_mem_wdata, a_rd_data});
    end
    // Release reset with the request still pending: it must be taken at once.
    rst = 1'b0;
    tick;
    req_valid = 1'b0;
    tests_run++;
    if (a_req_ready !== 1'b0 || a_mem_addr !== 16'hAAAA) begin
      tests_failed++; $display("FAIL reset_first_accept: got ready=%b addr=%h expected ready=0 addr=aaaa",
        a_req_ready, a_mem_addr);
    end
    do_reset;
  endtask

  task automatic test_read;
    logic [4:1] rd_pat  = 4'b0010;
    logic [4:1] rv_pat  = 4'b0100;
    logic [4:1] rdy_pat = 4'b1000;
    logic [7:0] e;
    do_reset;
    mem_ready = 1'b1; mem_rdata = 8'h5A; req_write = 1'b0; req_addr = 16'h1234; req_valid = 1'b1;
    exp_a.push_back(8'h5A);
    for (int k = 1; k <= 4; k++) begin
      tick;
      req_valid = 1'b0;
      tests_run++;
      if (a_mem_rd !== rd_pat[k]) begin
        tests_failed++; $display("FAIL read_mem_rd N+%0d: got %b expected %b", k, a_mem_rd, rd_pat[k]);
      end
      tests_run++;
      if (a_rd_valid !== rv_pat[k]) begin
        tests_failed++; $display("FAIL read_rd_valid N+%0d: got %b expected %b", k, a_rd_valid, rv_pat[k]);
      end
      tests_run++;
      if (a_req_ready !== rdy_pat[k] || a_busy !== ~rdy_pat[k]) begin
        tests_failed++; $display("FAIL read_ready N+%0d: got ready=%b busy=%b expected ready=%b",
          k, a_req_ready, a_busy, rdy_pat[k]);
      end
      if (k <= 3) begin
        tests_run++;
        if (a_mem_addr !== 16'h1234) begin
          tests_failed++; $display("FAIL read_addr N+%0d: got %h expected 1234", k, a_mem_addr);
        end
      end
      if (k == 2) begin
        tests_run++;
        if (a_rd_data !== 8'h00) begin
          tests_failed++; $display("FAIL read_early_data: got %h expected 00", a_rd_data);
        end
      end
      if (a_rd_valid) begin
        tests_run++;
        if (exp_a.size() == 0) begin
          tests_failed++; $display("FAIL sb_a_unexpected: rd_valid with data %h, expected no read", a_rd_data);
        end else begin
          e = exp_a.pop_front();
          if (a_rd_data !== e) begin
            tests_failed++; $display("FAIL read_data_a: got %h expected %h", a_rd_data, e);
          end
          $display("[TB] dut_a read addr=1234 data=%h", a_rd_data);
        end
      end
    end
    tests_run++;
    if (exp_a.size() != 0) begin
      tests_failed++; $display("FAIL read_sb_leftover: got %0d pending expected 0", exp_a.size());
    end
  endtask

  task automatic test_write_wait;
    int  s = 0;
    bit  done = 1'b0;
    do_reset;
    run_read(16'h0042, 8'h77);
    mem_ready = 1'b0; req_write = 1'b1; req_addr = 16'h00FF; req_wdata = 8'hC3; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (b_req_ready) begin
        done = 1'b1;
      end else begin
        tests_run++;
        if (b_mem_addr !== 16'h00FF || b_mem_wdata !== 8'hC3) begin
          tests_failed++; $display("FAIL write_stable: got addr=%h data=%h expected 00ff/c3", b_mem_addr, b_mem_wdata);
        end
        tests_run++;
        if (b_rd_valid !== 1'b0 || b_mem_rd !== 1'b0) begin
          tests_failed++; $display("FAIL write_no_read: got rd_valid=%b mem_rd=%b expected 0/0", b_rd_valid, b_mem_rd);
        end
        if (b_mem_wr) s++;
        // Device becomes ready in the fifth strobe cycle.
        mem_ready = (s >= 5);
        tick;
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++; $display("FAIL write_done: got still busy expected idle within 30 cycles");
    end
    tests_run++;
    if (s != 5) begin
      tests_failed++; $display("FAIL write_wr_cycles: got %0d expected 5", s);
    end
    tests_run++;
    if (b_rd_data !== 8'h77) begin
      tests_failed++; $display("FAIL write_rd_data: got %h expected 77", b_rd_data);
    end
    tests_run++;
    if (b_mem_wdata !== 8'hC3 || b_mem_addr !== 16'h00FF) begin
      tests_failed++; $display("FAIL write_idle_hold: got addr=%h data=%h expected 00ff/c3", b_mem_addr, b_mem_wdata);
    end
    $display("[TB] dut_b write addr=00ff data=c3 strobe=%0d", s);
    run_read(16'h0010, 8'h81);
    tests_run++;
    if (a_mem_wdata !== 8'hC3 || b_mem_wdata !== 8'hC3) begin
      tests_failed++; $display("FAIL read_keeps_wdata: got a=%h b=%h expected c3", a_mem_wdata, b_mem_wdata);
    end
  endtask

  task automatic timeout_read(input logic [15:0] addr, input bit clear_held);
    int a_str = 0;
    int b_str = 0;
    bit started = 1'b0;
    logic [7:0] e;
    mem_ready = 1'b0; req_write = 1'b0; req_addr = addr; req_valid = 1'b1; err_clear = clear_held;
    exp_a.push_back(8'hFF);
    exp_b.push_back(8'hFF);
    tick;
    req_valid = 1'b0;
    for (int c = 0; c < 40 && !(started && a_req_ready && b_req_ready); c++) begin
      started = 1'b1;
      if (a_mem_rd) a_str++;
      if (b_mem_rd) b_str++;
      if (a_rd_valid) begin
        tests_run++;
        if (a_err !== 1'b1) begin
          tests_failed++; $display("FAIL timeout_err_a: got %b expected 1 (clear_held=%0d)", a_err, clear_held);
        end
        tests_run++;
        if (exp_a.size() == 0) begin
          tests_failed++; $display("FAIL sb_a_unexpected: rd_valid with data %h, expected no read", a_rd_data);
        end else begin
          e = exp_a.pop_front();
          if (a_rd_data !== e) begin
            tests_failed++; $display("FAIL timeout_data_a: got %h expected %h", a_rd_data, e);
          end
          $display("[TB] dut_a aborted read addr=%h data=%h", addr, a_rd_data);
        end
      end
      if (b_rd_valid) begin
        tests_run++;
        if (exp_b.size() == 0 || b_err !== 1'b1) begin
          tests_failed++; $display("FAIL timeout_b_hold: got err=%b pending=%0d expected err=1 pending=1", b_err, exp_b.size());
        end else begin
          e = exp_b.pop_front();
          if (b_rd_data !== e) begin
            tests_failed++; $display("FAIL timeout_data_b: got %h expected %h", b_rd_data, e);
          end
        end
      end
      tick;
    end
    tests_run++;
    if (a_str != 16 || b_str != 16) begin
      tests_failed++; $display("FAIL timeout_strobe_len: got a=%0d b=%0d expected 16", a_str, b_str);
    end
    tests_run++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      tests_failed++; $display("FAIL timeout_sb_leftover: got %0d/%0d expected 0/0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_timeout;
    do_reset;
    timeout_read(16'h0400, 1'b0);
    tick;
    tests_run++;
    if (a_err !== 1'b1 || b_err !== 1'b1) begin
      tests_failed++; $display("FAIL err_sticky: got a=%b b=%b expected 1", a_err, b_err);
    end
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    tests_run++;
    if (a_err !== 1'b0 || b_err !== 1'b0) begin
      tests_failed++; $display("FAIL err_clear: got a=%b b=%b expected 0", a_err, b_err);
    end
    // err_clear held through a second abort: the timeout edge still sets err.
    timeout_read(16'h0401, 1'b1);
    tests_run++;
    if (a_err !== 1'b0) begin
      tests_failed++; $display("FAIL err_clear_after_hold: got %b expected 0", a_err);
    end
    err_clear = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc[$];
    logic [15:0] latched = 16'h0;
    logic [7:0] e;
    do_reset;
    mem_ready = 1'b1; req_write = 1'b0; req_addr = 16'h1111; req_valid = 1'b1;
    for (int c = 0; c < 30 && acc.size() < 2; c++) begin
      if (a_req_ready) begin
        acc.push_back(c);
        latched = req_addr;
        mem_rdata = req_addr[7:0] ^ 8'hA5;
        exp_a.push_back(req_addr[7:0] ^ 8'hA5);
      end else begin
        tests_run++;
        if (a_mem_addr !== latched || a_busy !== 1'b1) begin
          tests_failed++; $display("FAIL b2b_busy: got addr=%h busy=%b expected addr=%h busy=1", a_mem_addr, a_busy, latched);
        end
      end
      if (a_rd_valid) begin
        tests_run++;
        if (exp_a.size() == 0) begin
          tests_failed++; $display("FAIL sb_a_unexpected: rd_valid with data %h, expected no read", a_rd_data);
        end else begin
          e = exp_a.pop_front();
          if (a_rd_data !== e) begin
            tests_failed++; $display("FAIL b2b_data: got %h expected %h", a_rd_data, e);
          end
          $display("[TB] dut_a b2b read data=%h", a_rd_data);
        end
      end
      tick;
      if (acc.size() == 1) req_addr = 16'h2222;
    end
    req_valid = 1'b0;
    tests_run++;
    if (acc.size() != 2) begin
      tests_failed++; $display("FAIL b2b_accepts: got %0d accepts expected 2", acc.size());
    end else if (acc[1] - acc[0] != 4) begin
      tests_failed++; $display("FAIL b2b_spacing: got %0d cycles expected 4", acc[1] - acc[0]);
    end
    for (int c = 0; c < 6; c++) begin
      if (a_rd_valid) begin
        tests_run++;
        if (exp_a.size() == 0) begin
          tests_failed++; $display("FAIL sb_a_unexpected: rd_valid with data %h, expected no read", a_rd_data);
        end else begin
          e = exp_a.pop_front();
          if (a_rd_data !== e || a_mem_addr !== 16'h2222) begin
            tests_failed++; $display("FAIL b2b_second: got data=%h addr=%h expected %h/2222", a_rd_data, a_mem_addr, e);
          end
          $display("[TB] dut_a b2b read data=%h", a_rd_data);
        end
      end
      tick;
    end
    tests_run++;
    if (exp_a.size() != 0) begin
      tests_failed++; $display("FAIL b2b_sb_leftover: got %0d expected 0", exp_a.size());
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    run_read(16'h0033, 8'h66);
    mem_ready = 1'b0; req_write = 1'b0; req_addr = 16'h0500; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    for (int c = 0; c < 5 && !a_mem_rd; c++) tick;
    tests_run++;
    if (a_mem_rd !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_strobe: got mem_rd=%b expected 1", a_mem_rd);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests_run++;
    if ({a_mem_rd, a_rd_valid, a_req_ready, a_busy} !== 4'b0010 || a_rd_data !== 8'h00) begin
      tests_failed++; $display("FAIL midreset_a: got rd=%b rv=%b rdy=%b busy=%b data=%h expected 0 0 1 0 00",
        a_mem_rd, a_rd_valid, a_req_ready, a_busy, a_rd_data);
    end
    tests_run++;
    if ({b_mem_rd, b_rd_valid, b_req_ready} !== 3'b001 || b_rd_data !== 8'h00) begin
      tests_failed++; $display("FAIL midreset_b: got rd=%b rv=%b rdy=%b data=%h expected 0 0 1 00",
        b_mem_rd, b_rd_valid, b_req_ready, b_rd_data);
    end
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      tests_run++;
      if (a_rd_valid || a_mem_rd || b_rd_valid || b_mem_rd) begin
        tests_failed++; $display("FAIL midreset_discard: got activity rv=%b%b rd=%b%b expected none",
          a_rd_valid, b_rd_valid, a_mem_rd, b_mem_rd);
      end
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_wait;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
